seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. Active-low segments and anodes.
- Decodes a packed hex word (0-F per digit) and scans one digit per slot.
- Adds per-digit blanking, decimal points, leading-zero suppression, tear-free frame latching and an anti-ghosting guard interval.
- Sits between the board-level top and the display pins. It replaces the single-digit static decoder path.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- SCAN_DIV, 100000: clock cycles per digit slot; must be >= 2.
- GUARD, 16: cycles at the start of each slot with all anodes off; legal range 0..SCAN_DIV-1.

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iData  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k; digit 0 is rightmost.
- iDp  in  NUM_DIGITS  1 = light the decimal point of digit k.
- iBlank  in  NUM_DIGITS  1 = digit k dark.
- iLzs  in  1  1 = leading-zero suppression enabled.
- oSeg  out  7  segments, active low; bit0=a ... bit6=g.
- oDp  out  1  decimal point, active low.
- oAn  out  NUM_DIGITS  anodes, active low; bit k = digit k.
- oFrame  out  1  one-cycle pulse when new inputs are latched.

Behaviour:
- Clock and reset: one clock, iClk. Reset iRst_n is asynchronous and active-low.
- Reset values:
  - cnt=0, idx=0.
  - Shadow regs: data=0, dp=0, blank=all 1, lzs=0.
  - oAn=all 1, oSeg=7'h7F, oDp=1, oFrame=0.
  - Reset asserted mid-scan forces these values immediately.
- Prescaler cnt: counts 0..SCAN_DIV-1 and wraps. tick = (cnt==SCAN_DIV-1).
- Digit index idx: advances on tick and wraps NUM_DIGITS-1 -> 0.
- Frame boundary (tick and idx==NUM_DIGITS-1):
  - Next edge: shadow <= {iData,iDp,iBlank,iLzs}, oFrame <= 1.
  - oFrame is 0 on all other cycles.
  - The first frame after reset is dark, because shadow blank is all 1.
  - Input changes mid-frame never reach the outputs before the next boundary.
- Suppression, from shadow only: digit k (k>=1) is suppressed when lzs=1 and nibbles NUM_DIGITS-1..k are all zero. Digit 0 is never suppressed.
- dark(k) = blank[k] OR suppressed(k).
- Outputs are registered. Values at edge t+1 are a function of cnt, idx and shadow at cycle t (one-cycle latency):
  - oAn: all 1 if cnt<GUARD or dark(idx); else all 1 except bit idx = 0.
  - oSeg: 7'h7F if dark(idx); else font(nibble idx).
  - oDp: 1 if dark(idx); else ~dp[idx].
- Font, active-low, hex value in g..a order, for digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Simultaneous events: the output computed on the boundary edge uses the old shadow. The new shadow applies from slot 0 onward.
- GUARD=0 gives no gap. NUM_DIGITS=1 gives a frame boundary on every tick.
- Widths: cnt width = clog2(SCAN_DIV); idx width = max(1, clog2(NUM_DIGITS)).
- Out-of-range parameters fail elaboration.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 7'h7F.
  - The 16-entry active-low font constant.
  - Parameter-check helper constants.
- One sub-module: hex7seg_decoder. It is combinational, maps a 4-bit nibble to the 7-bit active-low pattern from the package font, and has full 0-F coverage with no default fallback to 0.
- Scan counter, shadow registers and suppression logic stay in seg7_scan_ctrl.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, GUARD=2 unless noted):
1. Reset:
   - Hold iRst_n low -> oAn=4'hF, oSeg=7'h7F, oDp=1, oFrame=0.
   - Drop iRst_n asynchronously mid-slot -> the same values before the next edge.
2. Decode and scan:
   - Stimulus: iData=16'h1234, iBlank=0, iLzs=0.
   - oFrame pulses 32 cycles after reset release.
   - In the next frame, slot 0 gives oAn=4'b1110 with oSeg=7'h19 for slot cycles 2..7 and oAn=4'hF for cycles 0..1.
   - Slot 3 gives oAn=4'b0111 with oSeg=7'h79.
3. Tear-free latch: change iData to 16'hABCD mid-frame -> the frame still shows 1,2,3,4; after the next oFrame, slot 0 shows 7'h21 and slot 3 shows 7'h08.
4. Leading-zero suppression:
   - iData=16'h0050, iLzs=1 -> oAn stays 4'hF in slots 3 and 2; slot 1 shows 7'h12; slot 0 shows 7'h40.
   - iData=0 -> only slot 0 lights, with 7'h40.
5. Blank and DP:
   - iBlank=4'b0100, iDp=4'b0001 -> slot 2 oAn=4'hF, oSeg=7'h7F, oDp=1.
   - Slot 0 gives oDp=0 while its anode is low; oDp=1 in other slots.
6. Guard sweep:
   - GUARD=0 -> an anode is low on every cycle of every lit slot.
   - GUARD=7 -> exactly one lit cycle per slot.
   - NUM_DIGITS=1 -> oFrame pulses every 8 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment driver: active-low font,
// blank pattern and parameter legality helpers.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low segment patterns in g..a bit order for hex digits 0..F
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam int unsigned MIN_DIGITS   = 1;
  localparam int unsigned MAX_DIGITS   = 8;
  localparam int unsigned MIN_SCAN_DIV = 2;

  function automatic bit params_ok(input int unsigned n, input int unsigned div,
                                   input int unsigned guard);
    return (n >= MIN_DIGITS) && (n <= MAX_DIGITS) &&
           (div >= MIN_SCAN_DIV) && (guard < div);
  endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module hex7seg_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o_c
);

  always_comb begin
    seg_o_c = SEG_OFF;
    case (nib_i)
      4'h0: seg_o_c = FONT[0];
      4'h1: seg_o_c = FONT[1];
      4'h2: seg_o_c = FONT[2];
      4'h3: seg_o_c = FONT[3];
      4'h4: seg_o_c = FONT[4];
      4'h5: seg_o_c = FONT[5];
      4'h6: seg_o_c = FONT[6];
      4'h7: seg_o_c = FONT[7];
      4'h8: seg_o_c = FONT[8];
      4'h9: seg_o_c = FONT[9];
      4'hA: seg_o_c = FONT[10];
      4'hB: seg_o_c = FONT[11];
      4'hC: seg_o_c = FONT[12];
      4'hD: seg_o_c = FONT[13];
      4'hE: seg_o_c = FONT[14];
      4'hF: seg_o_c = FONT[15];
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with frame-latched
// shadow inputs, leading-zero suppression and an anti-ghosting guard gap.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned GUARD      = 16
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic [4*NUM_DIGITS-1:0]   iData,
  input  logic [NUM_DIGITS-1:0]     iDp,
  input  logic [NUM_DIGITS-1:0]     iBlank,
  input  logic                      iLzs,
  output logic [6:0]                oSeg,
  output logic                      oDp,
  output logic [NUM_DIGITS-1:0]     oAn,
  output logic                      oFrame
);

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ALL_OFF  = '1;

  if (!params_ok(NUM_DIGITS, SCAN_DIV, GUARD)) begin : g_param_err
    $error("seg7_scan_ctrl: illegal NUM_DIGITS/SCAN_DIV/GUARD combination");
  end

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [NUM_DIGITS-1:0] dp_q, dp_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  lzs_q, lzs_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic                  frame_q, frame_d;

  logic                  tick_c;
  logic                  frame_c;
  logic                  guard_c;
  logic                  dark_c;
  logic                  all_zero_c;
  logic [NUM_DIGITS-1:0] supp_c;
  logic [3:0]            nib_c;
  logic [6:0]            font_c;

  assign tick_c  = (cnt_q == CNT_LAST);
  assign frame_c = tick_c && (idx_q == IDX_LAST);

  if (GUARD == 0) begin : g_no_guard
    assign guard_c = 1'b0;
  end else begin : g_guard
    assign guard_c = (cnt_q < CNT_W'(GUARD));
  end

  // A digit is suppressed when it and every more-significant nibble are zero
  always_comb begin
    all_zero_c = 1'b1;
    supp_c     = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero_c = all_zero_c & (data_q[4*k +: 4] == 4'h0);
      supp_c[k]  = lzs_q & all_zero_c;
    end
  end

  assign nib_c  = data_q[{idx_q, 2'b00} +: 4];
  assign dark_c = blank_q[idx_q] | supp_c[idx_q];

  hex7seg_decoder u_dec (
    .nib_i   (nib_c),
    .seg_o_c (font_c)
  );

  always_comb begin
    cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    lzs_d   = lzs_q;
    an_d    = ALL_OFF;
    seg_d   = dark_c ? SEG_OFF : font_c;
    dpo_d   = dark_c | ~dp_q[idx_q];
    frame_d = frame_c;

    if (tick_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    // New inputs take effect only at the frame boundary to avoid tearing
    if (frame_c) begin
      data_d  = iData;
      dp_d    = iDp;
      blank_d = iBlank;
      lzs_d   = iLzs;
    end
    if (!guard_c && !dark_c) begin
      an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '1;
      lzs_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= SEG_OFF;
      dpo_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      lzs_q   <= lzs_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      frame_q <= frame_d;
    end
  end

  assign oAn    = an_q;
  assign oSeg   = seg_q;
  assign oDp    = dpo_q;
  assign oFrame = frame_q;

endmodule
